// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with registered one-hot grant and index.
// Define RR_ARBITER8_TIMEOUT_EN to build the hold-time watchdog (limit HOLD_MAX cycles).
module rr_arbiter8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0] state;
  logic [2:0] last;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       pick_found;
  logic       owner_release;
  logic       hold_expire;

  // Rotating priority search: starts one past the last owner and wraps, so the
  // last owner itself is examined last.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pick_idx   = last;
    pick_found = 1'b0;
    cand       = last;
    for (int i = 1; i <= 8; i++) begin
      cand = last + 3'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_release = done || !req[grant_idx];

`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  logic [7:0] hold_cnt;

  // Counter is zero whenever not in GRANT, so it is cleared on every GRANT entry.
  assign hold_expire = (hold_cnt + 8'd1) == HOLD_LIM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= (state == S_GRANT) ? hold_cnt + 8'd1 : 8'd0;
      timeout  <= (state == S_GRANT) && !owner_release && hold_expire;
    end
  end
`else
  logic unused_hold;

  assign unused_hold = ^8'(HOLD_MAX);
  assign hold_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      last        <= 3'd7;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_idx   <= pick_idx;
            grant       <= 8'h01 << pick_idx;
            grant_valid <= 1'b1;
            state       <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (owner_release || hold_expire) begin
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            state       <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          last  <= grant_idx;
          state <= S_IDLE;
        end
        default: begin
          grant       <= 8'h00;
          grant_valid <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed-vector bench for rr_arbiter8 (HOLD_MAX = 4).
// Compiles the watchdog scenario when RR_ARBITER8_TIMEOUT_EN is defined, else the hold-forever one.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int nvec = 0;
  int nerr = 0;

  logic [12:0] obs;
  assign obs = {grant, grant_idx, grant_valid, timeout};

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    repeat (2) tick();
    nvec++;
    if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL reset_values: got %h want %h", obs, {8'h00, 3'd0, 1'b0, 1'b0});
    end
    reset = 1'b0;
    req   = 8'h10;
    tick();
    nvec++;
    if (obs !== {8'h10, 3'd4, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL pre_reset_grant: got %h want %h", obs, {8'h10, 3'd4, 1'b1, 1'b0});
    end
    #1 reset = 1'b1;
    #1;
    nvec++;
    if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL async_reset_clear: got %h want %h", obs, {8'h00, 3'd0, 1'b0, 1'b0});
    end
    req   = 8'hFF;
    reset = 1'b0;
    tick();
    nvec++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL first_grant_after_reset: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_rotation();
    logic [7:0] eg;
    logic [2:0] ei;
    logic [2:0] pi;
    do_reset();
    req = 8'hFF;
    tick();
    nvec++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL rot_first: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
    for (int k = 1; k <= 8; k++) begin
      pi   = 3'(k - 1);
      ei   = 3'(k % 8);
      eg   = 8'h01 << ei;
      done = 1'b1;
      tick();
      done = 1'b0;
      nvec++;
      if (obs !== {8'h00, pi, 1'b0, 1'b0}) begin
        nerr++; $display("FAIL rot_gap1 step %0d: got %h want %h", k, obs, {8'h00, pi, 1'b0, 1'b0});
      end
      tick();
      nvec++;
      if (obs !== {8'h00, pi, 1'b0, 1'b0}) begin
        nerr++; $display("FAIL rot_gap2 step %0d: got %h want %h", k, obs, {8'h00, pi, 1'b0, 1'b0});
      end
      tick();
      nvec++;
      if (obs !== {eg, ei, 1'b1, 1'b0}) begin
        nerr++; $display("FAIL rot_grant step %0d: got %h want %h", k, obs, {eg, ei, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req = 8'h40;
    tick();
    nvec++;
    if (obs !== {8'h40, 3'd6, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL wrap_owner6: got %h want %h", obs, {8'h40, 3'd6, 1'b1, 1'b0});
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'b0000_0101;
    repeat (2) tick();
    nvec++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL wrap_to_0: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (2) tick();
    nvec++;
    if (obs !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL skip_to_2: got %h want %h", obs, {8'h04, 3'd2, 1'b1, 1'b0});
    end
  endtask

  task automatic test_implicit_release();
    do_reset();
    req = 8'h08;
    tick();
    nvec++;
    if (obs !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL impl_owner3: got %h want %h", obs, {8'h08, 3'd3, 1'b1, 1'b0});
    end
    req = 8'h0C;
    tick();
    nvec++;
    if (obs !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL impl_nonowner_change: got %h want %h", obs, {8'h08, 3'd3, 1'b1, 1'b0});
    end
    req = 8'h21;
    tick();
    nvec++;
    if (obs !== {8'h00, 3'd3, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL impl_release: got %h want %h", obs, {8'h00, 3'd3, 1'b0, 1'b0});
    end
    repeat (2) tick();
    nvec++;
    if (obs !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL impl_next5: got %h want %h", obs, {8'h20, 3'd5, 1'b1, 1'b0});
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (2) tick();
    nvec++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL impl_next0: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_done_ignored();
    do_reset();
    done = 1'b1;
    tick();
    nvec++;
    if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL idle_no_req: got %h want %h", obs, {8'h00, 3'd0, 1'b0, 1'b0});
    end
    req = 8'h01;
    tick();
    nvec++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL idle_done_ignored: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
    tick();
    done = 1'b0;
    nvec++;
    if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL min_ownership: got %h want %h", obs, {8'h00, 3'd0, 1'b0, 1'b0});
    end
  endtask

`ifdef RR_ARBITER8_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 8'h02;
    for (int c = 1; c <= 4; c++) begin
      tick();
      nvec++;
      if (obs !== {8'h02, 3'd1, 1'b1, 1'b0}) begin
        nerr++; $display("FAIL to_hold cycle %0d: got %h want %h", c, obs, {8'h02, 3'd1, 1'b1, 1'b0});
      end
    end
    tick();
    nvec++;
    if (obs !== {8'h00, 3'd1, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL to_pulse: got %h want %h", obs, {8'h00, 3'd1, 1'b0, 1'b1});
    end
    tick();
    nvec++;
    if (obs !== {8'h00, 3'd1, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL to_pulse_end: got %h want %h", obs, {8'h00, 3'd1, 1'b0, 1'b0});
    end
    tick();
    nvec++;
    if (obs !== {8'h02, 3'd1, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL to_regrant: got %h want %h", obs, {8'h02, 3'd1, 1'b1, 1'b0});
    end
    repeat (3) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    nvec++;
    if (obs !== {8'h00, 3'd1, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL to_coincident_done: got %h want %h", obs, {8'h00, 3'd1, 1'b0, 1'b0});
    end
  endtask
`else
  task automatic test_hold_forever();
    do_reset();
    req = 8'h80;
    for (int c = 1; c <= 300; c++) begin
      tick();
      nvec++;
      if (obs !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
        nerr++; $display("FAIL hold_forever cycle %0d: got %h want %h", c, obs, {8'h80, 3'd7, 1'b1, 1'b0});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_implicit_release();
    test_done_ignored();
`ifdef RR_ARBITER8_TIMEOUT_EN
    test_timeout();
`else
    test_hold_forever();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
